// File: rtl/seg7_scan_if.sv
// Bundle of the data-side and pin-side signals of the seg7_scan display scanner.
// master: the data source / pin consumer; slave: the scanner itself.
interface seg7_scan_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   dots;
  logic [NDIG-1:0]   blink;
  logic              load;
  logic              lz_blank;
  logic [3:0]        bright;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic              frame_tick;

  modport master (
    output data, dots, blink, load, lz_blank, bright,
    input  seg, dig_sel, frame_tick
  );

  modport slave (
    input  data, dots, blink, load, lz_blank, bright,
    output seg, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed N-digit hex 7-segment scanner with double-buffered load,
// leading-zero blanking, per-digit dots, 16-level PWM brightness, a guard
// interval at the start of every digit slot, and a frame tick.
// Optional per-digit blinking is built when SEG7_SCAN_BLINK_EN is defined.
// Segment bit order [7:0] = {B,A,F,C,G,D,Dot,E}.
module seg7_scan #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned DIV_LOG2    = 14,
  parameter int unsigned GUARD       = 64,
  parameter int unsigned SEG_ACT_LOW = 0,
  parameter int unsigned DIG_ACT_LOW = 0
) (
  input  logic       clk,
  input  logic       rstn,
  seg7_scan_if.slave io
);
  localparam int unsigned         IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0]       IDX_LAST = IW'(NDIG - 1);
  localparam logic [DIV_LOG2-1:0] GUARD_SC = DIV_LOG2'(GUARD);
  localparam logic [7:0]          SEG_OFF  = (SEG_ACT_LOW != 0) ? '1 : '0;
  localparam logic [NDIG-1:0]     DIG_OFF  = (DIG_ACT_LOW != 0) ? '1 : '0;

  logic [4*NDIG-1:0]   data_q;
  logic [NDIG-1:0]     dots_q;
  logic [NDIG-1:0]     blank;
  logic [DIV_LOG2-1:0] sc_q, sc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          bright_q, bright_d;
  logic [3:0]          nib_q, nib_d;
  logic                dot_q, dot_d;
  logic                off_q, off_d;
  logic [7:0]          glyph;
  logic [7:0]          seg_q, seg_d;
  logic [NDIG-1:0]     dig_q, dig_d;
  logic                wrap, tick, lit, lead;

  // Shadow registers: capture the source on the load strobe, hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      dots_q <= '0;
    end else if (io.load) begin
      data_q <= io.data;
      dots_q <= io.dots;
    end
  end

`ifdef SEG7_SCAN_BLINK_EN
  logic [NDIG-1:0] blink_q;
  logic [5:0]      frame_q;

  // Blink shadow and 6-bit frame counter; bit 5 gives 32 frames on / 32 off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_q <= '0;
      frame_q <= '0;
    end else begin
      if (io.load) blink_q <= io.blink;
      if (tick)    frame_q <= frame_q + 6'd1;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^io.blink;
`endif

  // Slot counter and digit index; the index advances when the slot wraps.
  always_comb begin
    wrap  = &sc_q;
    tick  = wrap && (idx_q == IDX_LAST);
    sc_d  = sc_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Leading-zero run from the top digit down; digit 0 is never blanked.
  always_comb begin
    lead  = io.lz_blank;
    blank = '0;
    for (int unsigned i = NDIG - 1; i >= 1; i--) begin
      lead     = lead && (data_q[4*i +: 4] == 4'h0) && !dots_q[i];
      blank[i] = lead;
    end
  end

  // At slot start the live shadow/brightness feed the output directly and are
  // latched for the rest of the slot, so the first slot cycle is not stale.
  always_comb begin
    nib_d    = nib_q;
    dot_d    = dot_q;
    off_d    = off_q;
    bright_d = bright_q;
    if (sc_q == '0) begin
      bright_d = io.bright;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (idx_q == IW'(i)) begin
          nib_d = data_q[4*i +: 4];
          dot_d = dots_q[i];
`ifdef SEG7_SCAN_BLINK_EN
          off_d = blank[i] | (blink_q[i] & frame_q[5]);
`else
          off_d = blank[i];
`endif
        end
      end
    end
  end

  // Hex glyph, PWM/guard enable window and output polarity.
  always_comb begin
    case (nib_d)
      4'h0: glyph = 8'hF5;
      4'h1: glyph = 8'h90;
      4'h2: glyph = 8'hCD;
      4'h3: glyph = 8'hDC;
      4'h4: glyph = 8'hB8;
      4'h5: glyph = 8'h7C;
      4'h6: glyph = 8'h7D;
      4'h7: glyph = 8'hD0;
      4'h8: glyph = 8'hFD;
      4'h9: glyph = 8'hFC;
      4'hA: glyph = 8'hF9;
      4'hB: glyph = 8'h3D;
      4'hC: glyph = 8'h65;
      4'hD: glyph = 8'h9D;
      4'hE: glyph = 8'h6D;
      default: glyph = 8'h69;
    endcase
    lit   = (sc_q >= GUARD_SC) && (sc_q[DIV_LOG2-1 -: 4] <= bright_d) && !off_d;
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    if (lit) begin
      seg_d = (glyph | {6'b0, dot_d, 1'b0}) ^ SEG_OFF;
      dig_d = (NDIG'(1) << idx_q) ^ DIG_OFF;
    end
  end

  // Scan state, slot latches and registered pin outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc_q     <= '0;
      idx_q    <= '0;
      bright_q <= '0;
      nib_q    <= '0;
      dot_q    <= 1'b0;
      off_q    <= 1'b0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
    end else begin
      sc_q     <= sc_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      nib_q    <= nib_d;
      dot_q    <= dot_d;
      off_q    <= off_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign io.seg        = seg_q;
  assign io.dig_sel    = dig_q;
  assign io.frame_tick = tick;
endmodule
